ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_arbiter: round-robin CPU/loader arbiter for a single-port sync RAM.  |
// | Optional CPU lock: define ARB_LOCK_EN.  Revision: 1.0                    |
// +--------------------------------------------------------------------------+
module ram_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              cpu_ack,
  output logic              ld_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GNT_C = 3'd1,
    GNT_L = 3'd2,
    ACK_C = 3'd3,
    ACK_L = 3'd4
  } state_t;

  localparam logic c_gnt_cpu = 1'b0;
  localparam logic c_gnt_ld  = 1'b1;

  state_t            r_state;
  logic              r_last_gnt;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_we;
  logic              r_cpu_ack;
  logic              r_ld_ack;
  logic              r_busy;
  logic              w_pick_cpu;
  logic              w_lock_go;

  // Tie goes to whoever was not granted last.
  assign w_pick_cpu = cpu_req && (!ld_req || (r_last_gnt == c_gnt_ld));

`ifdef ARB_LOCK_EN
  localparam logic [3:0] c_lock_last = 4'(LOCK_MAX - 1);
  logic [3:0] r_lock_cnt;
  assign w_lock_go = cpu_lock && cpu_req && (r_lock_cnt < c_lock_last);
`else
  logic w_unused_cfg;
  assign w_lock_go    = 1'b0;
  assign w_unused_cfg = cpu_lock & (LOCK_MAX > 0);
`endif

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state     <= IDLE;
      r_last_gnt  <= c_gnt_ld;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_ld_ack    <= 1'b0;
      r_busy      <= 1'b0;
`ifdef ARB_LOCK_EN
      r_lock_cnt  <= '0;
`endif
    end else begin
      r_ram_we  <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_ld_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_cpu) begin
            r_state     <= GNT_C;
            r_last_gnt  <= c_gnt_cpu;
            r_ram_addr  <= cpu_addr;
            r_ram_wdata <= cpu_wdata;
            r_ram_we    <= cpu_we;
            r_busy      <= 1'b1;
          end else if (ld_req) begin
            r_state     <= GNT_L;
            r_last_gnt  <= c_gnt_ld;
            r_ram_addr  <= ld_addr;
            r_ram_wdata <= ld_wdata;
            r_ram_we    <= ld_we;
            r_busy      <= 1'b1;
          end else begin
            r_busy      <= 1'b0;
          end
        end
        GNT_C: begin
          r_state   <= ACK_C;
          r_cpu_ack <= 1'b1;
          r_busy    <= 1'b1;
        end
        GNT_L: begin
          r_state  <= ACK_L;
          r_ld_ack <= 1'b1;
          r_busy   <= 1'b1;
        end
        ACK_C: begin
          if (w_lock_go) begin
            // Locked burst: re-grant the CPU without passing through IDLE.
            r_state     <= GNT_C;
            r_last_gnt  <= c_gnt_cpu;
            r_ram_addr  <= cpu_addr;
            r_ram_wdata <= cpu_wdata;
            r_ram_we    <= cpu_we;
            r_busy      <= 1'b1;
`ifdef ARB_LOCK_EN
            r_lock_cnt  <= r_lock_cnt + 4'd1;
`endif
          end else begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
`ifdef ARB_LOCK_EN
            r_lock_cnt  <= '0;
`endif
          end
        end
        ACK_L: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = r_ram_we;
  assign cpu_ack   = r_cpu_ack;
  assign ld_ack    = r_ld_ack;
  assign busy      = r_busy;
  assign rdata     = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// Directed self-checking bench for ram_arbiter with a behavioural sync-read RAM.
module tb_ram_arbiter;

  logic       clock = 1'b0;
  logic       clear;
  logic       cpu_req, cpu_we, cpu_lock;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       ld_req, ld_we;
  logic [7:0] ld_addr, ld_wdata;
  logic [7:0] ram_rdata;
  logic [7:0] ram_addr, ram_wdata;
  logic       ram_we, cpu_ack, ld_ack, busy;
  logic [7:0] rdata;

  logic [7:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(4)) dut (
    .clock(clock), .clear(clear),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .cpu_ack(cpu_ack), .ld_ack(ld_ack),
    .rdata(rdata), .busy(busy)
  );

  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = 8'h00; ld_wdata = 8'h00;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    repeat (2) @(negedge clock);
    clear = 1'b1;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || ram_we !== 1'b0 || cpu_ack !== 1'b0 || ld_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b ram_we=%b cpu_ack=%b ld_ack=%b, want all 0",
               busy, ram_we, cpu_ack, ld_ack);
    end
    checks++;
    if (ram_addr !== 8'h00 || ram_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: ram_addr=%h ram_wdata=%h, want 00 00", ram_addr, ram_wdata);
    end
    clear = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: busy=%b want 0", busy);
    end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'h10 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_gnt: busy=%b ram_we=%b ram_addr=%h cpu_ack=%b, want 1 0 10 0",
               busy, ram_we, ram_addr, cpu_ack);
    end
    @(negedge clock);
    checks++;
    if (cpu_ack !== 1'b1 || ld_ack !== 1'b0 || rdata !== 8'h5A) begin
      errors++;
      $display("FAIL cpu_read_ack: cpu_ack=%b ld_ack=%b rdata=%h, want 1 0 5a",
               cpu_ack, ld_ack, rdata);
    end
    cpu_req = 1'b0;
    @(negedge clock);
    checks++;
    if (cpu_ack !== 1'b0 || ld_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_done: cpu_ack=%b ld_ack=%b busy=%b, want 0 0 0",
               cpu_ack, ld_ack, busy);
    end
  endtask

  task automatic test_loader_write();
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h03; ld_wdata = 8'hC3;
    @(negedge clock);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h03 || ram_wdata !== 8'hC3 || ld_ack !== 1'b0) begin
      errors++;
      $display("FAIL ld_write_gnt: ram_we=%b ram_addr=%h ram_wdata=%h ld_ack=%b, want 1 03 c3 0",
               ram_we, ram_addr, ram_wdata, ld_ack);
    end
    @(negedge clock);
    checks++;
    if (ram_we !== 1'b0 || ld_ack !== 1'b1 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL ld_write_ack: ram_we=%b ld_ack=%b cpu_ack=%b, want 0 1 0",
               ram_we, ld_ack, cpu_ack);
    end
    ld_req = 1'b0; ld_we = 1'b0;
    @(negedge clock);
    checks++;
    if (mem[3] !== 8'hC3 || ld_ack !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL ld_write_mem: mem[03]=%h ld_ack=%b ram_we=%b, want c3 0 0",
               mem[3], ld_ack, ram_we);
    end
  endtask

  // Both requesters held; masks give expected per-cycle outputs for cycles 1..12.
  task automatic run_pattern(input string name, input logic [12:0] m_cack,
                             input logic [12:0] m_lack, input logic [12:0] m_busy,
                             input logic [12:0] m_gc, input logic [12:0] m_gl);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      checks++;
      if (cpu_ack !== m_cack[n] || ld_ack !== m_lack[n] || busy !== m_busy[n]) begin
        errors++;
        $display("FAIL %s_cyc%0d: cpu_ack=%b ld_ack=%b busy=%b, want %b %b %b",
                 name, n, cpu_ack, ld_ack, busy, m_cack[n], m_lack[n], m_busy[n]);
      end
      if (m_gc[n]) begin
        checks++;
        if (ram_addr !== 8'h10) begin
          errors++;
          $display("FAIL %s_gnt_cpu%0d: ram_addr=%h want 10", name, n, ram_addr);
        end
      end
      if (m_gl[n]) begin
        checks++;
        if (ram_addr !== 8'h03) begin
          errors++;
          $display("FAIL %s_gnt_ld%0d: ram_addr=%h want 03", name, n, ram_addr);
        end
      end
      if (m_cack[n]) begin
        checks++;
        if (rdata !== 8'h5A) begin
          errors++;
          $display("FAIL %s_cpu_rdata%0d: rdata=%h want 5a", name, n, rdata);
        end
      end
      if (m_lack[n]) begin
        checks++;
        if (rdata !== 8'hC3) begin
          errors++;
          $display("FAIL %s_ld_rdata%0d: rdata=%h want c3", name, n, rdata);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; cpu_lock = 1'b0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h03;
    // cycle n: n%3==1 grant, n%3==2 ack, n%3==0 idle; grants alternate CPU, loader
    run_pattern("rr", 13'b0_0001_0000_0100, 13'b0_1000_0010_0000,
                13'b0_1101_1011_0110, 13'b0_0000_1000_0010, 13'b0_0100_0001_0000);
    idle_inputs();
    repeat (3) @(negedge clock);
  endtask

  task automatic test_lock();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; cpu_lock = 1'b1;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h03;
`ifdef ARB_LOCK_EN
    // four CPU accesses back to back (1..8), IDLE at 9, loader 10..11, IDLE at 12
    run_pattern("lock", 13'b0_0001_0101_0100, 13'b0_1000_0000_0000,
                13'b0_1101_1111_1110, 13'b0_0000_1010_1010, 13'b0_0100_0000_0000);
`else
    run_pattern("nolock", 13'b0_0001_0000_0100, 13'b0_1000_0010_0000,
                13'b0_1101_1011_0110, 13'b0_0000_1000_0010, 13'b0_0100_0001_0000);
`endif
    idle_inputs();
    repeat (3) @(negedge clock);
  endtask

  task automatic test_clear_mid();
    do_reset();
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h20; ld_wdata = 8'h77;
    @(negedge clock);
    checks++;
    if (ram_we !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_gnt: ram_we=%b busy=%b, want 1 1", ram_we, busy);
    end
    clear = 1'b0;
    @(negedge clock);
    checks++;
    if (ld_ack !== 1'b0 || ram_we !== 1'b0 || busy !== 1'b0 || ram_addr !== 8'h00) begin
      errors++;
      $display("FAIL clr_abort: ld_ack=%b ram_we=%b busy=%b ram_addr=%h, want 0 0 0 00",
               ld_ack, ram_we, busy, ram_addr);
    end
    clear = 1'b1;
    @(negedge clock);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h20 || ram_wdata !== 8'h77 || ld_ack !== 1'b0) begin
      errors++;
      $display("FAIL clr_regnt: ram_we=%b ram_addr=%h ram_wdata=%h ld_ack=%b, want 1 20 77 0",
               ram_we, ram_addr, ram_wdata, ld_ack);
    end
    @(negedge clock);
    checks++;
    if (ld_ack !== 1'b1 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL clr_ack: ld_ack=%b ram_we=%b, want 1 0", ld_ack, ram_we);
    end
    idle_inputs();
    @(negedge clock);
    checks++;
    if (ld_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_done: ld_ack=%b busy=%b, want 0 0", ld_ack, busy);
    end
  endtask

  task automatic test_drop_req();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h99;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h30) begin
      errors++;
      $display("FAIL drop_gnt: busy=%b ram_we=%b ram_addr=%h, want 1 1 30", busy, ram_we, ram_addr);
    end
    cpu_req = 1'b0;
    @(negedge clock);
    checks++;
    if (cpu_ack !== 1'b1 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL drop_ack: cpu_ack=%b ram_we=%b, want 1 0", cpu_ack, ram_we);
    end
    @(negedge clock);
    checks++;
    if (cpu_ack !== 1'b0 || busy !== 1'b0 || mem[8'h30] !== 8'h99) begin
      errors++;
      $display("FAIL drop_done: cpu_ack=%b busy=%b mem[30]=%h, want 0 0 99",
               cpu_ack, busy, mem[8'h30]);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_quiet: cpu_ack=%b busy=%b, want 0 0", cpu_ack, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    mem[8'h10] <= 8'h5A;
    clear = 1'b0;
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_loader_write();
    test_round_robin();
    test_lock();
    test_clear_mid();
    test_drop_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
